// File: rtl/window3x3_pkg.sv
// Shared definitions for the 3x3 RGB888 window pipeline: FSM encoding,
// channel slice positions, tap count and fixed-point helpers.
package window3x3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } stateT;

  localparam int NTAPS      = 9;
  localparam int CENTER_TAP = 4;
  localparam int COEF_W_DEF = 8;

  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  // Half-LSB rounding offset applied before the arithmetic right shift.
  function automatic int roundConst(input int shift);
    return (shift == 0) ? 0 : (1 << (shift - 1));
  endfunction

endpackage

// File: rtl/mac_channel.sv
// One 8-bit colour channel: serial signed MAC over the window taps, then
// round, arithmetic shift and clamp to 0..255 into a held output register.
module mac_channel
  import window3x3_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEF,
  parameter int SHIFT  = 4,
  parameter int ACC_W  = COEF_W + 13
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iClear,
  input  logic              iEn,
  input  logic              iLatch,
  input  logic [7:0]        iPix,
  input  logic [COEF_W-1:0] iCoef,
  output logic [7:0]        oPix
);

  localparam int PROD_W = COEF_W + 9;
  localparam logic signed [ACC_W:0] RND = (ACC_W + 1)'(roundConst(SHIFT));

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prodExt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W:0]    rounded;
  logic signed [ACC_W:0]    scaled;
  logic [7:0]               clamped;

  // Pixel is zero-extended so it always reads as a non-negative operand.
  assign prod    = PROD_W'($signed({1'b0, iPix})) * PROD_W'($signed(iCoef));
  assign prodExt = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

  assign rounded = {acc[ACC_W-1], acc} + RND;
  assign scaled  = rounded >>> SHIFT;

  always_comb begin
    clamped = scaled[7:0];
    if (scaled[ACC_W]) begin
      clamped = 8'd0;
    end else if (|scaled[ACC_W-1:8]) begin
      clamped = 8'hFF;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      acc  <= '0;
      oPix <= '0;
    end else begin
      if (iClear) begin
        acc <= '0;
      end else if (iEn) begin
        acc <= acc + prodExt;
      end
      if (iLatch) begin
        oPix <= clamped;
      end
    end
  end

endmodule

// File: rtl/conv3x3_mac_rgb888.sv
// 3x3 RGB888 convolution consumer: latches one window per iValid, runs a
// 9-cycle serial MAC on R/G/B in parallel and emits one clamped pixel.
module conv3x3_mac_rgb888
  import window3x3_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEF,
  parameter int SHIFT  = 4,
  parameter int ACC_W  = COEF_W + 13
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iValid,
  input  logic [23:0]       iWin0,
  input  logic [23:0]       iWin1,
  input  logic [23:0]       iWin2,
  input  logic [23:0]       iWin3,
  input  logic [23:0]       iWin4,
  input  logic [23:0]       iWin5,
  input  logic [23:0]       iWin6,
  input  logic [23:0]       iWin7,
  input  logic [23:0]       iWin8,
  output logic              oBusy,
  input  logic              iCoefWe,
  input  logic [3:0]        iCoefAddr,
  input  logic [COEF_W-1:0] iCoefData,
  output logic [23:0]       oPixel,
  output logic              oValid
);

  localparam logic [COEF_W-1:0] IDENT = COEF_W'(1 << SHIFT);

  stateT             state;
  stateT             nextState;
  logic [23:0]       win  [NTAPS];
  logic [COEF_W-1:0] coef [NTAPS];
  logic [3:0]        tap;
  logic              capture;
  logic              lastTap;
  logic              coefWrOk;
  logic              accEn;
  logic              outLatch;
  logic [23:0]       pixSel;
  logic [COEF_W-1:0] coefSel;
  logic [7:0]        rOut;
  logic [7:0]        gOut;
  logic [7:0]        bOut;

  assign capture  = (state == IDLE) && iValid;
  assign accEn    = (state == ACC);
  assign outLatch = (state == OUT);
  assign lastTap  = (tap == 4'(NTAPS - 1));
  assign coefWrOk = (state == IDLE) && iCoefWe && (iCoefAddr <= 4'(NTAPS - 1));
  assign pixSel   = win[tap];
  assign coefSel  = coef[tap];

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (iValid) nextState = ACC;
      ACC:     if (lastTap) nextState = OUT;
      OUT:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Busy is registered from nextState so it drops in the oValid cycle,
  // letting the generator hand over the next window with no bubble.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      tap    <= '0;
      oBusy  <= 1'b0;
      oValid <= 1'b0;
    end else begin
      oBusy  <= (nextState != IDLE);
      oValid <= outLatch;
      if (capture) begin
        tap <= '0;
      end else if (accEn) begin
        tap <= lastTap ? 4'd0 : tap + 4'd1;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (capture) begin
      win[0] <= iWin0;
      win[1] <= iWin1;
      win[2] <= iWin2;
      win[3] <= iWin3;
      win[4] <= iWin4;
      win[5] <= iWin5;
      win[6] <= iWin6;
      win[7] <= iWin7;
      win[8] <= iWin8;
    end
  end

  // A write in the same IDLE cycle as iValid lands before tap 0 is read.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      for (int i = 0; i < NTAPS; i++) begin
        coef[i] <= (i == CENTER_TAP) ? IDENT : '0;
      end
    end else if (coefWrOk) begin
      coef[iCoefAddr] <= iCoefData;
    end
  end

  mac_channel #(.COEF_W(COEF_W), .SHIFT(SHIFT), .ACC_W(ACC_W)) uMacR (
    .iClk   (iClk),
    .iRst   (iRst),
    .iClear (capture),
    .iEn    (accEn),
    .iLatch (outLatch),
    .iPix   (pixSel[R_LSB +: 8]),
    .iCoef  (coefSel),
    .oPix   (rOut)
  );

  mac_channel #(.COEF_W(COEF_W), .SHIFT(SHIFT), .ACC_W(ACC_W)) uMacG (
    .iClk   (iClk),
    .iRst   (iRst),
    .iClear (capture),
    .iEn    (accEn),
    .iLatch (outLatch),
    .iPix   (pixSel[G_LSB +: 8]),
    .iCoef  (coefSel),
    .oPix   (gOut)
  );

  mac_channel #(.COEF_W(COEF_W), .SHIFT(SHIFT), .ACC_W(ACC_W)) uMacB (
    .iClk   (iClk),
    .iRst   (iRst),
    .iClear (capture),
    .iEn    (accEn),
    .iLatch (outLatch),
    .iPix   (pixSel[B_LSB +: 8]),
    .iCoef  (coefSel),
    .oPix   (bOut)
  );

  assign oPixel = {rOut, gOut, bOut};

endmodule

// File: tb/tb_conv3x3_mac_rgb888.sv
// Directed bench for conv3x3_mac_rgb888: table of kernel/window vectors plus
// hand-written busy, back-to-back and mid-operation reset sequences.
module tb_conv3x3_mac_rgb888;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iValid;
  logic        oBusy;
  logic        iCoefWe;
  logic [3:0]  iCoefAddr;
  logic [7:0]  iCoefData;
  logic [23:0] oPixel;
  logic        oValid;
  logic [23:0] win [9];

  int nTests   = 0;
  int nFail    = 0;
  int validCnt = 0;

  typedef struct {
    string            name;
    logic [8:0][7:0]  coef;
    logic [8:0][23:0] win;
    logic [23:0]      exp;
  } vecT;

  vecT vecs [7];

  always #5 iClk = ~iClk;

  always @(posedge iClk) if (oValid === 1'b1) validCnt++;

  conv3x3_mac_rgb888 dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iValid    (iValid),
    .iWin0     (win[0]),
    .iWin1     (win[1]),
    .iWin2     (win[2]),
    .iWin3     (win[3]),
    .iWin4     (win[4]),
    .iWin5     (win[5]),
    .iWin6     (win[6]),
    .iWin7     (win[7]),
    .iWin8     (win[8]),
    .oBusy     (oBusy),
    .iCoefWe   (iCoefWe),
    .iCoefAddr (iCoefAddr),
    .iCoefData (iCoefData),
    .oPixel    (oPixel),
    .oValid    (oValid)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic setWin(input logic [23:0] v);
    for (int t = 0; t < 9; t++) win[t] = v;
  endtask

  task automatic writeCoef(input logic [3:0] a, input logic [7:0] d);
    iCoefWe = 1'b1; iCoefAddr = a; iCoefData = d;
    @(negedge iClk);
    iCoefWe = 1'b0;
  endtask

  task automatic waitValid(input int maxc, output int cyc);
    cyc = 0;
    while (oValid !== 1'b1 && cyc < maxc) begin
      @(negedge iClk);
      cyc++;
    end
  endtask

  // Pulses iValid, then checks latency, busy length and result; ends one
  // cycle after the oValid cycle.
  task automatic pulseAndCheck(input logic [23:0] exp, input string nm);
    int k;
    int busy;
    iValid = 1'b1;
    @(negedge iClk);
    iValid = 1'b0;
    k = 0; busy = 0;
    while (oValid !== 1'b1 && k < 30) begin
      if (oBusy === 1'b1) busy++;
      @(negedge iClk);
      k++;
    end
    check({nm, "_valid"}, oValid, 1);
    check({nm, "_latency"}, k, 10);
    check({nm, "_busyCycles"}, busy, 10);
    check({nm, "_busyInValid"}, oBusy, 0);
    check({nm, "_pixel"}, oPixel, exp);
    @(negedge iClk);
    check({nm, "_pulseWidth"}, oValid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int snap;

    for (int i = 0; i < 7; i++) begin
      vecs[i].coef = '0;
      vecs[i].win  = '0;
    end
    vecs[0].name = "allOnes";
    vecs[0].coef = {9{8'd1}};
    vecs[0].win  = {9{24'h101010}};
    vecs[0].exp  = 24'h090909;
    vecs[1].name = "negClamp";
    vecs[1].coef[4] = 8'hF0;
    vecs[1].win[4]  = 24'hFF8001;
    vecs[1].exp  = 24'h000000;
    vecs[2].name = "posClamp";
    vecs[2].coef[4] = 8'd127;
    vecs[2].win  = {9{24'hFFFFFF}};
    vecs[2].win[4]  = 24'h0102FF;
    vecs[2].exp  = 24'h0810FF;
    vecs[3].name = "tap0Only";
    vecs[3].coef[0] = 8'd16;
    vecs[3].win  = {9{24'h777777}};
    vecs[3].win[0]  = 24'hAABBCC;
    vecs[3].exp  = 24'hAABBCC;
    vecs[4].name = "tap8Only";
    vecs[4].coef[8] = 8'd16;
    vecs[4].win  = {9{24'hFFFFFF}};
    vecs[4].win[8]  = 24'h123456;
    vecs[4].exp  = 24'h123456;
    vecs[5].name = "roundHalf";
    vecs[5].coef[4] = 8'd8;
    vecs[5].win[4]  = 24'h0305FF;
    vecs[5].exp  = 24'h020380;
    vecs[6].name = "negMix";
    vecs[6].coef[3] = 8'hF0;
    vecs[6].coef[4] = 8'd32;
    vecs[6].win[3]  = 24'h204010;
    vecs[6].win[4]  = 24'h102030;
    vecs[6].exp  = 24'h000050;

    iRst = 1'b1; iValid = 1'b0; iCoefWe = 1'b0; iCoefAddr = '0; iCoefData = '0;
    setWin(24'h0);
    repeat (3) @(negedge iClk);
    check("reset_busy", oBusy, 0);
    check("reset_valid", oValid, 0);
    check("reset_pixel", oPixel, 0);
    iRst = 1'b0;
    @(negedge iClk);

    setWin(24'h102030);
    pulseAndCheck(24'h102030, "identity");

    for (int i = 0; i < 7; i++) begin
      for (int t = 0; t < 9; t++) begin
        writeCoef(4'(t), vecs[i].coef[t]);
        win[t] = vecs[i].win[t];
      end
      pulseAndCheck(vecs[i].exp, vecs[i].name);
    end

    // iValid and a coefficient write while busy must both be ignored
    for (int t = 0; t < 9; t++) writeCoef(4'(t), (t == 4) ? 8'd16 : 8'd0);
    setWin(24'h102030);
    snap = validCnt;
    iValid = 1'b1;
    @(negedge iClk);
    iValid = 1'b0;
    repeat (3) @(negedge iClk);
    setWin(24'h050505);
    iValid = 1'b1; iCoefWe = 1'b1; iCoefAddr = 4'd4; iCoefData = 8'd0;
    @(negedge iClk);
    iValid = 1'b0; iCoefWe = 1'b0;
    waitValid(30, cyc);
    check("busy_valid", oValid, 1);
    check("busy_pixel", oPixel, 24'h102030);
    repeat (15) @(negedge iClk);
    check("busy_oneValid", validCnt - snap, 1);

    setWin(24'h405060);
    pulseAndCheck(24'h405060, "busyWriteDropped");

    writeCoef(4'd12, 8'd0);
    setWin(24'h102030);
    pulseAndCheck(24'h102030, "addr12Dropped");

    // Second window offered in the oValid cycle
    setWin(24'h112233);
    iValid = 1'b1;
    @(negedge iClk);
    iValid = 1'b0;
    waitValid(30, cyc);
    check("b2b_first", oValid, 1);
    check("b2b_firstPixel", oPixel, 24'h112233);
    setWin(24'h445566);
    iValid = 1'b1;
    @(negedge iClk);
    iValid = 1'b0;
    waitValid(30, cyc);
    check("b2b_second", oValid, 1);
    check("b2b_spacing", cyc + 1, 11);
    check("b2b_secondPixel", oPixel, 24'h445566);
    @(negedge iClk);

    // Reset in ACC cycle 5 discards the window and restores identity
    for (int t = 0; t < 9; t++) writeCoef(4'(t), 8'd1);
    setWin(24'h101010);
    snap = validCnt;
    iValid = 1'b1;
    @(negedge iClk);
    iValid = 1'b0;
    repeat (4) @(negedge iClk);
    iRst = 1'b1;
    @(negedge iClk);
    check("midRst_busy", oBusy, 0);
    check("midRst_valid", oValid, 0);
    check("midRst_pixel", oPixel, 0);
    iRst = 1'b0;
    repeat (15) @(negedge iClk);
    check("midRst_noResult", validCnt - snap, 0);
    setWin(24'h102030);
    pulseAndCheck(24'h102030, "postRstIdentity");

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
